cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 113 +++++++++++
 tb/tb_cordic_sched.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Round-robin scheduler that shares one pipelined CORDIC between N_REQ requesters.
// Issue order is kept in a tag FIFO so each in-order result is routed back to its owner.
module cordic_sched #(
    parameter int WIDTH     = 24,
    parameter int N_REQ     = 4,
    parameter int MAX_OUT   = 16,
    parameter int ISSUE_GAP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_angle,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         cordic_angle,
    output logic                     cordic_data_loaded,
    input  logic [WIDTH-1:0]         cordic_x,
    input  logic [WIDTH-1:0]         cordic_y,
    input  logic                     cordic_data_computed,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_sin,
    output logic [WIDTH-1:0]         rsp_cos,
    output logic                     busy,
    output logic                     err_unexpected
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    logic [IW-1:0] last_gnt;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;
    logic          gnt_any;
    logic          can_issue;
    logic          pop_ok;
    logic [CW-1:0] out_cnt;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] tag_mem [MAX_OUT];

    // Full check uses the registered count, so a same-cycle pop cannot unblock a grant.
    assign can_issue = !rst && (out_cnt != CW'(MAX_OUT)) && (gap_cnt == '0);
    assign pop_ok    = cordic_data_computed && (out_cnt != '0);
    assign busy      = (out_cnt != '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(last_gnt) + i) % N_REQ);
            if (can_issue && !gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;

    // NOTE: tag storage is deliberately not reset; the pointers and count alone decide validity.
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            tag_mem[wr_ptr] <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt           <= IW'(N_REQ - 1);
            gap_cnt            <= '0;
            out_cnt            <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            cordic_angle       <= '0;
            cordic_data_loaded <= 1'b0;
            rsp_valid          <= '0;
            rsp_sin            <= '0;
            rsp_cos            <= '0;
            err_unexpected     <= 1'b0;
        end else begin
            cordic_data_loaded <= gnt_any;
            if (gnt_any) begin
                cordic_angle <= req_angle[gnt_idx*WIDTH +: WIDTH];
                last_gnt     <= gnt_idx;
                wr_ptr       <= wr_ptr + PW'(1);
                gap_cnt      <= GW'(ISSUE_GAP - 1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            rsp_valid <= '0;
            if (pop_ok) begin
                rsp_valid <= N_REQ'(1) << tag_mem[rd_ptr];
                rsp_sin   <= cordic_y;
                rsp_cos   <= cordic_x;
                rd_ptr    <= rd_ptr + PW'(1);
            end else if (cordic_data_computed) begin
                err_unexpected <= 1'b1;
            end

            case ({gnt_any, pop_ok})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Randomised bench for cordic_sched: a transaction-level model (queues, round-robin search)
// is compared with the DUT every cycle, and directed scenarios pin literal results.
module tb_cordic_sched;

    localparam int WIDTH     = 24;
    localparam int N_REQ     = 4;
    localparam int MAX_OUT   = 16;
    localparam int ISSUE_GAP = 1;
    localparam int LAT       = 3;

    typedef enum {M_IDLE, M_CONT, M_RAND} mode_t;
    typedef struct {
        logic [WIDTH-1:0] angle;
        int               ready;
    } pend_t;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_angle;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       cordic_angle;
    logic                   cordic_data_loaded;
    logic [WIDTH-1:0]       cordic_x;
    logic [WIDTH-1:0]       cordic_y;
    logic                   cordic_data_computed;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_sin;
    logic [WIDTH-1:0]       rsp_cos;
    logic                   busy;
    logic                   err_unexpected;

    cordic_sched #(
        .WIDTH(WIDTH), .N_REQ(N_REQ), .MAX_OUT(MAX_OUT), .ISSUE_GAP(ISSUE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_angle(req_angle), .gnt(gnt),
        .cordic_angle(cordic_angle), .cordic_data_loaded(cordic_data_loaded),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_data_computed(cordic_data_computed),
        .rsp_valid(rsp_valid), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    mode_t mode     = M_IDLE;
    logic  hold     = 1'b0;
    logic  spur_req = 1'b0;
    logic  stall_rand = 1'b0;
    int    release_cnt = 0;
    int    rel_cyc  = 0;
    pend_t pend[$];

    // observation records
    logic [N_REQ-1:0] seen_gnt = '0;
    int               gseq[$];
    int               gcyc[$];
    int               rseq[$];
    int               gnt_cnt[N_REQ];
    int               rsp_cnt[N_REQ];
    int               rsp_total = 0;
    logic [WIDTH-1:0] seen_sin[N_REQ];
    logic [WIDTH-1:0] seen_cos[N_REQ];

    // reference model state
    int               tagq[$];
    int               m_last = N_REQ - 1;
    int               m_gap  = 0;
    logic [WIDTH-1:0] m_angle = '0;
    logic             m_loaded = 1'b0;
    logic [N_REQ-1:0] m_rv = '0;
    logic [WIDTH-1:0] m_sin = '0;
    logic [WIDTH-1:0] m_cos = '0;
    logic             m_err = 1'b0;
    int               m_g;
    int               m_t;
    logic [N_REQ-1:0] m_eg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
        logic [N_REQ-1:0] s;
        for (int k = 1; k <= N_REQ; k++) begin
            s = r >> ((last + k) % N_REQ);
            if (s[0]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic real to_rad(input logic [WIDTH-1:0] a);
        int ai;
        ai = $signed(a);
        return $itor(ai) / 1048576.0;
    endfunction

    function automatic logic [WIDTH-1:0] to_fx(input real v);
        return WIDTH'($rtoi(v * 1048576.0));
    endfunction

    // Ideal in-order CORDIC stand-in with fixed latency, optional stalls and hold-off.
    initial begin
        pend_t p;
        cordic_data_computed = 1'b0;
        cordic_x = '0;
        cordic_y = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cordic_data_loaded) pend.push_back('{cordic_angle, cyc + LAT});
            cordic_data_computed = 1'b0;
            if (spur_req) begin
                spur_req = 1'b0;
                cordic_data_computed = 1'b1;
                cordic_x = WIDTH'($urandom);
                cordic_y = WIDTH'($urandom);
            end else if (pend.size() > 0 && pend[0].ready <= cyc && (!hold || release_cnt > 0)
                         && !(stall_rand && $urandom_range(0, 2) == 0)) begin
                p = pend.pop_front();
                if (hold) begin
                    release_cnt--;
                    rel_cyc = cyc;
                end
                cordic_data_computed = 1'b1;
                cordic_x = to_fx($cos(to_rad(p.angle)));
                cordic_y = to_fx($sin(to_rad(p.angle)));
            end
        end
    end

    // Requester behaviour: drop after grant, re-request in continuous/random modes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && seen_gnt[i]) begin
                    req[i] = 1'b0;
                    if (mode == M_CONT) begin
                        req[i] = 1'b1;
                        req_angle[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    end
                end
                if (mode == M_RAND) begin
                    if (req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
                    else if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
                    req_angle[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
        end
    end

    // Compare process: check outputs against the model, then advance the model one cycle.
    always @(negedge clk) begin
        m_g = -1;
        if (!rst && tagq.size() < MAX_OUT && m_gap == 0) m_g = rr_pick(req, m_last);
        m_eg = (m_g >= 0) ? (N_REQ'(1) << m_g) : '0;

        check("gnt", 64'(gnt), 64'(m_eg));
        check("cordic_data_loaded", 64'(cordic_data_loaded), 64'(m_loaded));
        check("cordic_angle", 64'(cordic_angle), 64'(m_angle));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        check("rsp_sin", 64'(rsp_sin), 64'(m_sin));
        check("rsp_cos", 64'(rsp_cos), 64'(m_cos));
        check("busy", 64'(busy), 64'(tagq.size() != 0));
        check("err_unexpected", 64'(err_unexpected), 64'(m_err));

        seen_gnt = gnt;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gseq.push_back(i);
                gcyc.push_back(cyc);
                gnt_cnt[i]++;
            end
            if (rsp_valid[i]) begin
                rseq.push_back(i);
                rsp_cnt[i]++;
                rsp_total++;
                seen_sin[i] = rsp_sin;
                seen_cos[i] = rsp_cos;
            end
        end

        if (rst) begin
            tagq.delete();
            m_last = N_REQ - 1;
            m_gap = 0;
            m_angle = '0;
            m_loaded = 1'b0;
            m_rv = '0;
            m_sin = '0;
            m_cos = '0;
            m_err = 1'b0;
        end else begin
            m_rv = '0;
            if (cordic_data_computed) begin
                if (tagq.size() > 0) begin
                    m_t = tagq.pop_front();
                    m_rv = N_REQ'(1) << m_t;
                    m_sin = cordic_y;
                    m_cos = cordic_x;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_loaded = (m_g >= 0);
            if (m_g >= 0) begin
                tagq.push_back(m_g);
                m_last = m_g;
                m_angle = req_angle[m_g*WIDTH +: WIDTH];
                m_gap = ISSUE_GAP - 1;
            end else if (m_gap > 0) begin
                m_gap--;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_stats();
        gseq.delete();
        gcyc.delete();
        rseq.delete();
        rsp_total = 0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_cnt[i] = 0;
            rsp_cnt[i] = 0;
        end
    endtask

    task automatic wait_rsp(input int n, input string name);
        int k = 0;
        while (rsp_total < n && k < 400) begin
            tick(1);
            k++;
        end
        check({name, "_rsp_done"}, 64'(rsp_total >= n), 64'd1);
    endtask

    task automatic wait_gnt(input int n, input string name);
        int k = 0;
        while (gseq.size() < n && k < 600) begin
            tick(1);
            k++;
        end
        check({name, "_gnt_done"}, 64'(gseq.size() >= n), 64'd1);
    endtask

    initial begin
        int fall_cyc;
        int n_iss;
        rst = 1'b1;
        req = '0;
        req_angle = '0;
        tick(3);
        check("reset_gnt", 64'(gnt), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_loaded", 64'(cordic_data_loaded), 64'd0);
        check("reset_err", 64'(err_unexpected), 64'd0);
        check("reset_rsp_sin", 64'(rsp_sin), 64'd0);
        rst = 1'b0;
        clear_stats();

        // single requester, angle 1.0 rad
        req_angle[0 +: WIDTH] = 24'h100000;
        req[0] = 1'b1;
        wait_rsp(1, "single");
        tick(LAT + 3);
        check("single_gnt_cnt", 64'(gnt_cnt[0]), 64'd1);
        check("single_rsp_cnt", 64'(rsp_total), 64'd1);
        check("single_sin_hi", 64'(seen_sin[0][23:8]), 64'h0D76);
        check("single_cos_hi", 64'(seen_cos[0][23:8]), 64'h08A5);

        // two simultaneous requesters, angles 0 and -1.0 rad
        clear_stats();
        req_angle[1*WIDTH +: WIDTH] = 24'h000000;
        req_angle[2*WIDTH +: WIDTH] = 24'hF00000;
        req[1] = 1'b1;
        req[2] = 1'b1;
        wait_rsp(2, "pair");
        tick(3);
        check("pair_first_gnt", 64'(gseq.size() > 0 ? gseq[0] : -1), 64'd1);
        check("pair_sin1", 64'(seen_sin[1][23:8]), 64'h0000);
        check("pair_cos1", 64'(seen_cos[1][23:8]), 64'h1000);
        check("pair_sin2", 64'(seen_sin[2][23:8]), 64'hF289);
        check("pair_cos2", 64'(seen_cos[2][23:8]), 64'h08A5);

        // all four held high from reset: strict rotation, one grant per cycle
        rst = 1'b1;
        pend.delete();
        req = '1;
        mode = M_CONT;
        tick(2);
        rst = 1'b0;
        fall_cyc = cyc;
        clear_stats();
        tick(16);
        check("rr_gnt_count", 64'(gseq.size() >= 8), 64'd1);
        check("rr_rsp_count", 64'(rseq.size() >= 8), 64'd1);
        if (gseq.size() >= 8 && rseq.size() >= 8) begin
            check("rr_first_gnt_cycle", 64'(gcyc[0]), 64'(fall_cyc));
            for (int k = 0; k < 8; k++) begin
                check("rr_gnt_order", 64'(gseq[k]), 64'(k % N_REQ));
                check("rr_rsp_order", 64'(rseq[k]), 64'(k % N_REQ));
                if (k < 7) check("rr_back_to_back", 64'(gcyc[k+1] - gcyc[k]), 64'd1);
            end
        end

        // results withheld: exactly MAX_OUT grants, then one more per released result
        rst = 1'b1;
        pend.delete();
        hold = 1'b1;
        tick(2);
        rst = 1'b0;
        clear_stats();
        tick(MAX_OUT + 6);
        check("full_grants", 64'(gseq.size()), 64'(MAX_OUT));
        check("full_gnt_zero", 64'(gnt), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        release_cnt = 1;
        tick(4);
        check("full_regrant", 64'(gseq.size()), 64'(MAX_OUT + 1));
        if (gseq.size() == MAX_OUT + 1)
            check("full_regrant_cycle", 64'(gcyc[MAX_OUT]), 64'(rel_cyc + 1));
        tick(3);
        check("full_single_regrant", 64'(gseq.size()), 64'(MAX_OUT + 1));
        mode = M_IDLE;
        req = '0;
        hold = 1'b0;
        wait_rsp(MAX_OUT + 1, "full_drain");

        // spurious result strobe with nothing outstanding
        rst = 1'b1;
        pend.delete();
        tick(2);
        rst = 1'b0;
        clear_stats();
        spur_req = 1'b1;
        tick(4);
        check("spur_err_set", 64'(err_unexpected), 64'd1);
        check("spur_no_rsp", 64'(rsp_total), 64'd0);
        tick(6);
        check("spur_err_sticky", 64'(err_unexpected), 64'd1);
        rst = 1'b1;
        tick(1);
        check("spur_err_cleared", 64'(err_unexpected), 64'd0);

        // reset with five results in flight; stale strobes must not reach requesters
        pend.delete();
        req = '1;
        mode = M_CONT;
        hold = 1'b1;
        tick(1);
        rst = 1'b0;
        clear_stats();
        wait_gnt(5, "midrst");
        check("midrst_inflight", 64'(gseq.size()), 64'd5);
        check("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        req = '0;
        mode = M_IDLE;
        hold = 1'b0;
        tick(1);
        check("midrst_busy_after", 64'(busy), 64'd0);
        tick(1);
        rst = 1'b0;
        clear_stats();
        tick(LAT + 10);
        check("midrst_no_rsp", 64'(rsp_total), 64'd0);
        check("midrst_late_err", 64'(err_unexpected), 64'd1);

        // 2*MAX_OUT+3 issues across the FIFO wrap, random stalls
        rst = 1'b1;
        pend.delete();
        tick(2);
        rst = 1'b0;
        clear_stats();
        stall_rand = 1'b1;
        mode = M_RAND;
        wait_gnt(2 * MAX_OUT + 3, "wrap");
        mode = M_IDLE;
        req = '0;
        n_iss = gseq.size();
        wait_rsp(n_iss, "wrap");
        tick(2);
        check("wrap_rsp_total", 64'(rsp_total), 64'(n_iss));
        check("wrap_no_err", 64'(err_unexpected), 64'd0);
        check("wrap_idle", 64'(busy), 64'd0);

        // random soak with occasional spurious strobes
        mode = M_RAND;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) spur_req = 1'b1;
            tick(1);
        end
        mode = M_IDLE;
        req = '0;
        stall_rand = 1'b0;
        tick(60);
        check("soak_idle_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
